// File: rtl/fp_div_arb_pkg.sv
// fp_div_arb_pkg: shared arbiter state encoding and IEEE-754 single-precision constants.
package fp_div_arb_pkg;
   typedef enum logic [2:0] {IDLE, ACCEPT, SEND_A, SEND_B, WAIT_Z, RETURN} state_e;
   localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
   localparam logic [31:0] FP_QNAN = 32'hFFC0_0000;
   localparam logic [31:0] FP_INF  = 32'h7F80_0000;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first asserted request at or after ptr_i with wrap.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDW = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDW-1:0]   ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IDW-1:0]   idx_o,
   output logic             any_o
);
   logic [IDW-1:0] j;
   always_comb begin
      idx_o = '0;
      j = '0;
      // walk from farthest to nearest so the closest request to ptr_i wins
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = IDW'((int'(ptr_i) + k) % N_REQ);
         idx_o = req_i[j] ? j : idx_o;
      end
      any_o = |req_i;
      gnt_o = any_o ? N_REQ'(1) << idx_o : '0;
   end
endmodule

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin sharing of one multi-cycle fp divider among N_REQ requesters,
// one division in flight; every strobe/ack it drives comes straight from a flop.
module fp_div_arbiter import fp_div_arb_pkg::*; #(
   parameter int N_REQ = 4,
   parameter int IDW = $clog2(N_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ*32-1:0] req_a,
   input  logic [N_REQ*32-1:0] req_b,
   input  logic [N_REQ-1:0]   req_stb,
   output logic [N_REQ-1:0]   req_ack,
   output logic [31:0]        rsp_z,
   output logic [N_REQ-1:0]   rsp_stb,
   input  logic [N_REQ-1:0]   rsp_ack,
   output logic [31:0]        div_a,
   output logic               div_a_stb,
   input  logic               div_a_ack,
   output logic [31:0]        div_b,
   output logic               div_b_stb,
   input  logic               div_b_ack,
   input  logic [31:0]        div_z,
   input  logic               div_z_stb,
   output logic               div_z_ack,
   output logic [IDW-1:0]     grant_id,
   output logic               busy,
   output logic [15:0]        ops_done
);
   state_e state_q, state_d;
   logic [IDW-1:0] grant_q, grant_d, rr_q, rr_d, pick_idx;
   logic [N_REQ-1:0] oh_q, oh_d, pick_gnt, req_ack_q, rsp_stb_q;
   logic [31:0] a_q, a_d, b_q, b_d, z_q, z_d;
   logic [15:0] ops_q, ops_d;
   logic pick_any, div_a_stb_q, div_b_stb_q, div_z_ack_q;
   rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
      .req_i(req_stb), .ptr_i(rr_q), .gnt_o(pick_gnt), .idx_o(pick_idx), .any_o(pick_any)
   );
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      oh_d = oh_q;
      rr_d = rr_q;
      a_d = a_q;
      b_d = b_q;
      z_d = z_q;
      ops_d = ops_q;
      case (state_q)
         IDLE: if (pick_any) begin
            grant_d = pick_idx;
            oh_d = pick_gnt;
            state_d = ACCEPT;
         end
         ACCEPT: if (|(req_ack_q & req_stb)) begin
            a_d = req_a[{grant_q, 5'd0} +: 32];
            b_d = req_b[{grant_q, 5'd0} +: 32];
            state_d = SEND_A;
         end
         SEND_A: state_d = (div_a_stb_q && div_a_ack) ? SEND_B : SEND_A;
         SEND_B: state_d = (div_b_stb_q && div_b_ack) ? WAIT_Z : SEND_B;
         WAIT_Z: if (div_z_ack_q && div_z_stb) begin
            z_d = div_z;
            state_d = RETURN;
         end
         RETURN: if (|(rsp_stb_q & rsp_ack)) begin
            rr_d = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
            ops_d = ops_q + 16'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         oh_q <= '0;
         rr_q <= '0;
         a_q <= '0;
         b_q <= '0;
         z_q <= '0;
         ops_q <= '0;
         req_ack_q <= '0;
         rsp_stb_q <= '0;
         div_a_stb_q <= 1'b0;
         div_b_stb_q <= 1'b0;
         div_z_ack_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         oh_q <= oh_d;
         rr_q <= rr_d;
         a_q <= a_d;
         b_q <= b_d;
         z_q <= z_d;
         ops_q <= ops_d;
         req_ack_q <= (state_d == ACCEPT) ? oh_d : '0;
         rsp_stb_q <= (state_d == RETURN) ? oh_d : '0;
         div_a_stb_q <= state_d == SEND_A;
         div_b_stb_q <= state_d == SEND_B;
         div_z_ack_q <= state_d == WAIT_Z;
      end
   end
   assign req_ack = req_ack_q;
   assign rsp_stb = rsp_stb_q;
   assign rsp_z = z_q;
   assign div_a = a_q;
   assign div_b = b_q;
   assign div_a_stb = div_a_stb_q;
   assign div_b_stb = div_b_stb_q;
   assign div_z_ack = div_z_ack_q;
   assign grant_id = grant_q;
   assign busy = state_q != IDLE;
   assign ops_done = ops_q;
endmodule

// File: tb/tb_fp_div_arbiter.sv
// tb_fp_div_arbiter: directed bench with a stand-in divider, requester agents and a
// cycle-by-cycle round-robin ownership model.
module tb_fp_div_arbiter;
   import fp_div_arb_pkg::*;
   localparam int N = 4;
   localparam int LAT = 4;
   logic clk = 1'b0, rst = 1'b1;
   logic [N*32-1:0] req_a = '0, req_b = '0;
   logic [N-1:0] req_stb = '0, req_ack, rsp_stb, rsp_ack, hold = '0;
   logic [31:0] rsp_z, div_a, div_b, div_z = '0;
   logic div_a_stb, div_b_stb, div_z_ack, busy;
   logic div_a_ack = 1'b1, div_b_ack = 1'b1, div_z_stb = 1'b0;
   logic [1:0] grant_id;
   logic [15:0] ops_done;
   assign rsp_ack = ~hold;
   always #5 clk = ~clk;

   fp_div_arbiter #(.N_REQ(N)) dut (
      .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
      .rsp_z(rsp_z), .rsp_stb(rsp_stb), .rsp_ack(rsp_ack),
      .div_a(div_a), .div_a_stb(div_a_stb), .div_a_ack(div_a_ack),
      .div_b(div_b), .div_b_stb(div_b_stb), .div_b_ack(div_b_ack),
      .div_z(div_z), .div_z_stb(div_z_stb), .div_z_ack(div_z_ack),
      .grant_id(grant_id), .busy(busy), .ops_done(ops_done)
   );

   typedef struct {logic [31:0] a, b, z;} op_t;
   op_t ops [N][16];
   int wr [N], iss [N], ret [N];
   int checks = 0, errors = 0;
   int m_ops = 0, m_ptr = 0, exp_g = 0, cnt = -1;
   bit exp_v = 0, chk_grant = 0;
   logic [31:0] m_a = '0, m_b = '0, da = '0, dz = '0;
   int glog [$];
   logic [31:0] zlog [$];
   logic [N-1:0] rsp_seen = '0;
   int ord [5] = '{0, 1, 2, 3, 0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // the stand-in divider only knows the hand-computed quotients used below
   function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h3F800000, 32'h40000000}: return 32'h3F000000;
         {32'h40C00000, 32'h40400000}: return 32'h40000000;
         {32'h41200000, 32'h40A00000}: return 32'h40000000;
         {32'h3F800000, 32'h3F800000}: return 32'h3F800000;
         {32'h40400000, 32'h3F800000}: return 32'h40400000;
         {32'h40A00000, 32'h40000000}: return 32'h40200000;
         {32'h42C80000, 32'h41200000}: return 32'h41200000;
         {32'h41000000, 32'h40800000}: return 32'h40000000;
         {32'h3F800000, 32'h00000000}: return 32'h7F800000;
         {32'h00000000, 32'h00000000}: return 32'hFFC00000;
         default: return 32'hDEADBEEF;
      endcase
   endfunction

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
      return 0;
   endfunction

   task automatic enq(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] z);
      ops[i][wr[i]] = '{a, b, z};
      wr[i]++;
   endtask

   task automatic wait_ops(input int n);
      int t = 0;
      while (m_ops < n && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("ops wait", m_ops, n);
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_rst();
      chk("rst req_ack", req_ack, 0);
      chk("rst rsp_stb", rsp_stb, 0);
      chk("rst div strobes", {div_a_stb, div_b_stb, div_z_ack}, 0);
      chk("rst div_a", div_a, 0);
      chk("rst div_b", div_b, 0);
      chk("rst rsp_z", rsp_z, 0);
      chk("rst busy", busy, 0);
      chk("rst grant_id", grant_id, 0);
      chk("rst ops_done", ops_done, 0);
   endtask

   initial begin : agent
      logic [N-1:0] rx, sx, own;
      bit ax, bx, zx;
      forever begin
         @(negedge clk);
         rx = req_stb & req_ack;
         sx = rsp_stb & rsp_ack;
         ax = div_a_stb & div_a_ack;
         bx = div_b_stb & div_b_ack;
         zx = div_z_stb & div_z_ack;
         own = exp_v ? N'(1) << exp_g : '0;
         if (!rst) begin
            rsp_seen |= rsp_stb;
            chk("ops_done", ops_done, m_ops[15:0]);
            if (chk_grant) begin
               chk("grant_id", grant_id, exp_g);
               chk("req_ack grant", req_ack, 1 << exp_g);
               chk_grant = 0;
            end
            chk("stray strobe", (req_ack | rsp_stb) & ~own, 0);
            if (!busy) chk("div_z_ack idle", div_z_ack, 0);
            if (div_a_stb) chk("div_a", div_a, m_a);
            if (div_b_stb) chk("div_b", div_b, m_b);
            if (!busy && !exp_v && |req_stb) begin
               exp_g = pick(req_stb, m_ptr);
               exp_v = 1;
               chk_grant = 1;
            end
            if (|rx) begin
               chk("accept port", rx, 1 << exp_g);
               m_a = ops[exp_g][iss[exp_g]].a;
               m_b = ops[exp_g][iss[exp_g]].b;
            end
            if (|sx) begin
               chk("rsp port", sx, own);
               chk("rsp_z", rsp_z, ops[exp_g][ret[exp_g]].z);
               glog.push_back(exp_g);
               zlog.push_back(rsp_z);
               m_ops++;
               m_ptr = (exp_g + 1) % N;
               exp_v = 0;
            end
         end
         @(posedge clk);
         #1;
         if (rst) begin
            req_stb = '0;
            for (int i = 0; i < N; i++) begin
               iss[i] = wr[i];
               ret[i] = wr[i];
            end
            exp_v = 0;
            chk_grant = 0;
            m_ops = 0;
            m_ptr = 0;
            cnt = -1;
            div_z_stb = 1'b0;
         end else begin
            for (int i = 0; i < N; i++) begin
               if (rx[i]) iss[i]++;
               if (sx[i]) ret[i]++;
            end
            if (ax) da = div_a;
            if (bx) begin
               dz = quot(da, div_b);
               cnt = LAT;
            end
            if (zx) div_z_stb = 1'b0;
            if (cnt == 0) begin
               div_z = dz;
               div_z_stb = 1'b1;
            end
            if (cnt >= 0) cnt--;
            for (int i = 0; i < N; i++) begin
               req_stb[i] = iss[i] < wr[i];
               req_a[32*i +: 32] = ops[i][iss[i]].a;
               req_b[32*i +: 32] = ops[i][iss[i]].b;
            end
         end
      end
   end

   initial begin : main
      int t;
      repeat (3) @(negedge clk);
      chk_rst();
      rst = 1'b0;
      rsp_seen = '0;
      enq(0, FP_ONE, 32'h40000000, 32'h3F000000);
      wait_ops(1);
      chk("t1 ops_done", ops_done, 1);
      chk("t1 z", zlog[0], 32'h3F000000);
      chk("t1 grant", glog[0], 0);
      chk("t1 rsp_seen", rsp_seen, 4'b0001);

      rst = 1'b1;
      @(negedge clk);
      chk_rst();
      rst = 1'b0;
      glog.delete();
      zlog.delete();
      enq(1, 32'h40C00000, 32'h40400000, 32'h40000000);
      enq(3, 32'h41200000, 32'h40A00000, 32'h40000000);
      wait_ops(2);
      chk("t2 first", glog[0], 1);
      chk("t2 first z", zlog[0], 32'h40000000);
      chk("t2 second", glog[1], 3);
      chk("t2 second z", zlog[1], 32'h40000000);

      glog.delete();
      zlog.delete();
      enq(0, FP_ONE, FP_ONE, FP_ONE);
      enq(1, 32'h40400000, FP_ONE, 32'h40400000);
      enq(2, 32'h40A00000, 32'h40000000, 32'h40200000);
      enq(3, 32'h42C80000, 32'h41200000, 32'h41200000);
      enq(0, 32'h41000000, 32'h40800000, 32'h40000000);
      wait_ops(7);
      for (int k = 0; k < 5; k++) chk("t3 order", glog[k], ord[k]);
      chk("t3 z 2.5", zlog[2], 32'h40200000);

      glog.delete();
      zlog.delete();
      enq(2, FP_ONE, 32'h0, FP_INF);
      enq(2, 32'h0, 32'h0, FP_QNAN);
      wait_ops(9);
      chk("t4 inf", zlog[0], 32'h7F800000);
      chk("t4 qnan", zlog[1], 32'hFFC00000);

      hold[1] = 1'b1;
      enq(1, 32'h40A00000, 32'h40000000, 32'h40200000);
      t = 0;
      while (!rsp_stb[1] && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("t5 reach return", rsp_stb[1], 1);
      repeat (20) begin
         @(negedge clk);
         chk("t5 stall stb", rsp_stb, 4'b0010);
         chk("t5 stall z", rsp_z, 32'h40200000);
         chk("t5 div idle", div_a_stb, 0);
      end
      @(posedge clk);
      #2 hold[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t5 released", rsp_stb, 0);
      chk("t5 ops_done", ops_done, 10);

      enq(3, 32'h42C80000, 32'h41200000, 32'h41200000);
      t = 0;
      while (!div_z_ack && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("t6 in wait_z", div_z_ack, 1);
      rst = 1'b1;
      @(negedge clk);
      chk_rst();
      rst = 1'b0;
      glog.delete();
      zlog.delete();
      enq(0, FP_ONE, FP_ONE, FP_ONE);
      wait_ops(1);
      chk("t6 ops_done", ops_done, 1);
      chk("t6 z", zlog[0], FP_ONE);
      chk("t6 grant", glog[0], 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
